// File: rtl/data_memory_responder_if.sv
// Memory Access stage <-> data memory bus: word address, store data/strobe,
// and the registered read data returned one cycle later.
interface data_memory_responder_if;
    logic [15:0] address_to_memory;
    logic [15:0] data_to_memory;
    logic        data_to_memory_write_en;
    logic [15:0] data_from_memory;

    modport master (
        output address_to_memory,
        output data_to_memory,
        output data_to_memory_write_en,
        input  data_from_memory
    );

    modport slave (
        input  address_to_memory,
        input  data_to_memory,
        input  data_to_memory_write_en,
        output data_from_memory
    );
endinterface

// File: rtl/data_memory_responder.sv
// Word-addressed data RAM plus a small I/O window (cycle counter, output
// register, synchronized input) answering the Memory Access stage with 1-cycle reads.
module data_memory_responder #(
    parameter int          ADDR_BITS = 10,
    parameter logic [15:0] IO_BASE   = 16'hFF00
) (
    input  logic                  clk,
    input  logic                  reset,
    data_memory_responder_if.slave mem,
    input  logic [15:0]           io_in,
    output logic [15:0]           io_out
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [15:0]          r_ram [DEPTH];
    logic [15:0]          r_ram_q;
    logic [15:0]          r_io_q;
    logic                 r_sel_ram;
    logic [15:0]          r_cycle;
    logic [15:0]          r_io_out;
    logic [15:0]          r_sync1;
    logic [15:0]          r_sync2;

    logic                 w_is_io;
    logic [15:0]          w_offset;
    logic [ADDR_BITS-1:0] w_idx;
    logic                 w_ram_we;
    logic                 w_io_out_we;
    logic [15:0]          w_io_rd;

    assign w_is_io     = (mem.address_to_memory >= IO_BASE);
    assign w_offset    = mem.address_to_memory - IO_BASE;
    assign w_idx       = mem.address_to_memory[ADDR_BITS-1:0];
    assign w_ram_we    = mem.data_to_memory_write_en && !w_is_io && !reset;
    assign w_io_out_we = mem.data_to_memory_write_en && w_is_io && (w_offset == 16'd1);

    // RAM and its read register carry no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_idx] <= mem.data_to_memory;
            r_ram_q      <= mem.data_to_memory;
        end else begin
            r_ram_q      <= r_ram[w_idx];
        end
    end

    always_comb begin
        w_io_rd = 16'd0;
        if (w_offset == 16'd0) begin
            w_io_rd = r_cycle;
        end else if (w_offset == 16'd1) begin
            w_io_rd = w_io_out_we ? mem.data_to_memory : r_io_out;
        end else if (w_offset == 16'd2) begin
            w_io_rd = r_sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle   <= 16'd0;
            r_io_out  <= 16'd0;
            r_sync1   <= 16'd0;
            r_sync2   <= 16'd0;
            r_io_q    <= 16'd0;
            r_sel_ram <= 1'b0;
        end else begin
            r_cycle   <= r_cycle + 16'd1;
            r_sync1   <= io_in;
            r_sync2   <= r_sync1;
            if (w_io_out_we) begin
                r_io_out <= mem.data_to_memory;
            end
            r_io_q    <= w_io_rd;
            r_sel_ram <= !w_is_io;
        end
    end

    // Output stays 0 after reset because r_sel_ram clears to the I/O path.
    assign mem.data_from_memory = r_sel_ram ? r_ram_q : r_io_q;
    assign io_out               = r_io_out;
endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Word-addressed data memory and memory-mapped I/O responder on the memory side of the Memory Access stage interface.
- Accepts the address, write data and write enable driven by the Memory Access stage.
- Returns read data on data_from_memory one cycle later.
- Owns the data RAM array, a free-running cycle counter, an output register and a synchronized input port.

Parameters:
- ADDR_BITS, 10, RAM index width; depth = 2^ADDR_BITS 16-bit words.
- IO_BASE, 16'hFF00, first address of the I/O window; addresses >= IO_BASE decode to I/O, all others to RAM.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- address_to_memory  input  16  word address from the Memory Access stage.
- data_to_memory  input  16  store data from the Memory Access stage.
- data_to_memory_write_en  input  1  store strobe, one write per asserted cycle.
- data_from_memory  output  16  registered read data for the address presented in the previous cycle.
- io_in  input  16  asynchronous external input word.
- io_out  output  16  software-writable output register.

Behaviour:
- Reset (reset high at an edge):
  - data_from_memory = 0, io_out = 0, cycle counter = 0, io_in synchronizer flops = 0.
  - RAM contents are not cleared.
  - Any write presented in a reset cycle is ignored, including RAM writes.
- Read latency is exactly 1 cycle. If the address is A at edge N, data_from_memory after edge N holds the contents of A. There is no valid/ready handshake; a read happens every cycle.
- Writes:
  - When data_to_memory_write_en = 1 at edge N, the target is updated at edge N.
  - data_from_memory after edge N equals the newly written value (write-first), for both RAM and io_out.
  - Writes to read-only locations leave data_from_memory reflecting the read-only value.
- RAM decode: address < IO_BASE selects RAM index address[ADDR_BITS-1:0]. Upper bits are ignored, so addresses alias modulo 2^ADDR_BITS.
- I/O decode (address >= IO_BASE), with offset = address - IO_BASE:
  - Offset 0, cycle counter: read-only. Increments by 1 every non-reset cycle and wraps from 16'hFFFF to 0. A read returns the counter value before the increment at that edge.
  - Offset 1, io_out: read/write.
  - Offset 2, io_in: read-only. Returns the output of a 2-flop synchronizer, so a change on io_in becomes visible 2 edges later.
  - Offsets 3 and above: read 0; writes are ignored.
- Back-to-back accesses:
  - Read A immediately after a write to A returns the new data.
  - Alternating read/write every cycle is sustained with no stalls.
- Read in the same cycle reset deasserts: the first edge with reset low performs a normal read.

Test Plan:
1. Reset, then write 16'h1234 to address 16'h0005 and read 16'h0005 the next cycle -> data_from_memory = 16'h1234 one cycle after the read address is presented.
2. Write 16'hBEEF to 16'h0007 with write_en = 1 -> data_from_memory = 16'hBEEF after the same edge (write-first). Then write 16'h0001 to 16'h0407 with ADDR_BITS = 10 and read 16'h0007 -> 16'h0001 (alias).
3. Write 16'h00A5 to 16'hFF01 -> io_out = 16'h00A5 after that edge. Assert reset for 1 cycle -> io_out = 0 and data_from_memory = 0. Read 16'h0005 after reset -> 16'h1234 (RAM preserved).
4. Hold address 16'hFF00 for 4 cycles after reset -> data_from_memory reads 0, 1, 2, 3. Force the counter to 16'hFFFF and advance one cycle -> the next read shows wrap to 0.
5. Change io_in from 0 to 16'h5A5A and read 16'hFF02 every cycle -> old value 0 for 2 edges, then 16'h5A5A.
6. Write 16'hFFFF to 16'hFF00 and to 16'hFF05 -> counter continues incrementing and is unaffected. Reads of 16'hFF05 return 0. Asserting write_en together with reset writes nothing.
